program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
- Upstream feeder for the processor's loading phase.
- Accepts a byte stream from a host link (UART or bench) framed as: magic, header, instruction words, data words, checksum.
- Packs the bytes into 32-bit words and presents each word on new_instruction with a one-cycle load_valid strobe. add_into selects instruction memory (0) or data memory (1).
- After a good checksum, asserts start_signal, then watches end_signal to report completion.

Parameters:
- MAGIC, 8'hB5, frame start byte.
- MAX_INSTR, 1024, maximum instruction word count accepted in the header.
- MAX_DATA, 1024, maximum data word count accepted in the header.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high.
- in_byte  input  8  host byte.
- in_valid  input  1  in_byte is valid.
- in_ready  output  1  loader accepts a byte this cycle. A transfer occurs when in_valid and in_ready are both high.
- new_instruction  output  32  word to processor memory.
- load_valid  output  1  new_instruction is valid this cycle. The processor writes its current memory when this is high.
- add_into  output  1  0 = instruction memory, 1 = data memory.
- start_signal  output  1  processor run enable; held high once set.
- end_signal  input  1  processor finished execution.
- done  output  1  program completed (sticky).
- error  output  1  frame rejected (sticky).

Behaviour:
- Reset values: in_ready=1, new_instruction=0, load_valid=0, add_into=0, start_signal=0, done=0, error=0.
- FSM states: IDLE, HDR, INSTR, DATA, CHECK, RUN, DONE, ERROR. Reset goes to IDLE from any state; a frame in progress is discarded and its counters cleared.
- in_ready is 1 in IDLE, HDR, INSTR, DATA and CHECK. It is 0 in RUN, DONE and ERROR.
- IDLE: a byte equal to MAGIC moves to HDR. Any other byte is dropped silently.
- HDR: four bytes, little-endian: icount[15:0] then dcount[15:0].
  - On the 4th byte, if icount>MAX_INSTR or dcount>MAX_DATA, go to ERROR.
  - Otherwise go to INSTR if icount>0, else DATA if dcount>0, else CHECK.
- Word packing: bytes are little-endian (first byte is [7:0]). A 2-bit byte counter wraps 3->0. On the 4th byte of a word, the registered word appears on new_instruction with load_valid=1 for exactly one cycle, in the cycle after that byte is accepted.
  - new_instruction holds its last value when load_valid=0.
  - Back-to-back words are separated by at least 3 cycles.
- INSTR: add_into=0. After icount words, go to DATA if dcount>0, else CHECK.
- DATA: add_into=1 from the cycle of the first data word's load_valid onward; it stays 1 through RUN and DONE. After dcount words, go to CHECK.
- Checksum: running 8-bit XOR of every header and payload byte (MAGIC excluded).
  - CHECK accepts one byte. If it equals the running XOR, go to RUN and assert start_signal the next cycle. Otherwise go to ERROR.
- RUN: start_signal=1. When end_signal is 1, go to DONE; done=1 the next cycle. start_signal stays 1.
- ERROR: error=1 and start_signal=0. The only exit is reset.
- A byte whose transfer coincides with the FSM state change is consumed by the old state only; no byte is consumed twice or lost.
- Word counters are 16 bits and compare against the latched header counts. The header values themselves are limited by MAX_*.
- If end_signal is asserted outside RUN, it is ignored.

Decomposition:
- Shared defines file (loader_defs): FSM state encodings, MAGIC default, header byte count (4), bytes per word (4).
- One sub-module: byte_packer. It holds the 2-bit byte counter and 32-bit shift register and outputs a word plus a one-cycle word_done strobe. program_loader contains the FSM, counts, checksum and handshake.

Test Plan:
- Frame B5, 02 00 01 00, 13 00 00 00, 93 00 10 00, EF BE AD DE, checksum -> load_valid pulses with new_instruction=00000013 (add_into=0), 00100093 (add_into=0), DEADBEEF (add_into=1); start_signal=1 one cycle after the checksum byte. Then end_signal=1 -> done=1 next cycle.
- Same frame with the checksum byte XORed with 01 -> error=1, start_signal stays 0, in_ready=0.
- Garbage bytes 00 FF 12 before B5 -> dropped; the frame then loads normally.
- Header icount=0, dcount=0, checksum 00 -> no load_valid pulses; start_signal=1.
- Header icount=MAX_INSTR+1 -> ERROR immediately after the 4th header byte, with no load_valid pulses.
- Reset asserted midway through the 2nd instruction word, then a full valid frame -> the partial word is never emitted and the new frame loads exactly as in the first scenario.

Source files
------------

// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: FSM states, frame constants, header layout.
// Imported by the loader top and its byte packer.
package program_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_INSTR,
    ST_DATA,
    ST_CHECK,
    ST_RUN,
    ST_DONE,
    ST_ERROR
  } state_t;

  localparam logic [7:0] MAGIC_DEFAULT = 8'hB5;
  localparam int         HDR_BYTES     = 4;
  localparam int         WORD_BYTES    = 4;

  // Little-endian header: icount arrives first, so it lands in the low half.
  typedef struct packed {
    logic [15:0] dcount;
    logic [15:0] icount;
  } hdr_t;

  function automatic logic is_load_state(input state_t s);
    return (s == ST_INSTR) || (s == ST_DATA);
  endfunction

endpackage

// File: rtl/program_loader_byte_packer.sv
// Packs accepted bytes little-endian into 32-bit words.
// Latency: word_dat/word_done one cycle after the 4th byte; word_last flags that byte combinationally.
// Backpressure: none, consumes every byte_vld cycle.
module program_loader_byte_packer
  import program_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        byte_vld,
  input  logic [7:0]  byte_dat,
  output logic        word_last,
  output logic [31:0] word_dat,
  output logic        word_done
);

  logic [1:0]  byte_cnt;
  logic [23:0] shift_dat;

  assign word_last = byte_vld && (byte_cnt == 2'(WORD_BYTES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      byte_cnt  <= '0;
      shift_dat <= '0;
      word_dat  <= '0;
      word_done <= 1'b0;
    end else begin
      word_done <= word_last;
      if (byte_vld) begin
        byte_cnt  <= byte_cnt + 2'd1;
        shift_dat <= {byte_dat, shift_dat[23:8]};
      end
      if (word_last) begin
        word_dat <= {byte_dat, shift_dat};
      end
    end
  end

endmodule

// File: rtl/program_loader.sv
// Frames a host byte stream (magic, header, instr words, data words, checksum) into memory loads, then runs the program.
// Latency: each word strobes load_valid one cycle after its last byte; start_signal one cycle after a good checksum.
// Backpressure: in_ready is high while a frame can be taken, low in RUN, DONE and ERROR.
module program_loader
  import program_loader_pkg::*;
#(
  parameter logic [7:0] MAGIC     = MAGIC_DEFAULT,
  parameter int         MAX_INSTR = 1024,
  parameter int         MAX_DATA  = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_byte,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] new_instruction,
  output logic        load_valid,
  output logic        add_into,
  output logic        start_signal,
  input  logic        end_signal,
  output logic        done,
  output logic        error
);

  localparam logic [15:0] MAX_INSTR_W = 16'(MAX_INSTR);
  localparam logic [15:0] MAX_DATA_W  = 16'(MAX_DATA);

  state_t      state, state_nxt;
  logic        byte_acc;
  logic [1:0]  hdr_cnt;
  logic [23:0] hdr_shift;
  hdr_t        hdr_full;
  hdr_t        hdr_q;
  logic        hdr_last;
  logic        hdr_bad;
  logic [15:0] word_cnt;
  logic [15:0] section_len;
  logic        section_last;
  logic [7:0]  csum;
  logic        pk_vld;
  logic        word_last;
  logic        add_into_q;

  assign in_ready = (state == ST_IDLE) || (state == ST_HDR) || is_load_state(state) ||
                    (state == ST_CHECK);
  assign byte_acc = in_valid && in_ready;
  assign pk_vld   = byte_acc && is_load_state(state);

  assign hdr_full = {in_byte, hdr_shift};
  assign hdr_last = byte_acc && (state == ST_HDR) && (hdr_cnt == 2'(HDR_BYTES - 1));
  assign hdr_bad  = (hdr_full.icount > MAX_INSTR_W) || (hdr_full.dcount > MAX_DATA_W);

  assign section_len  = (state == ST_INSTR) ? hdr_q.icount : hdr_q.dcount;
  assign section_last = word_last && ((word_cnt + 16'd1) == section_len);

  program_loader_byte_packer u_byte_packer (
    .clk       (clk),
    .reset     (reset),
    .byte_vld  (pk_vld),
    .byte_dat  (in_byte),
    .word_last (word_last),
    .word_dat  (new_instruction),
    .word_done (load_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (byte_acc && (in_byte == MAGIC)) state_nxt = ST_HDR;
      end
      ST_HDR: begin
        if (hdr_last) begin
          if (hdr_bad)                         state_nxt = ST_ERROR;
          else if (hdr_full.icount != 16'd0)   state_nxt = ST_INSTR;
          else if (hdr_full.dcount != 16'd0)   state_nxt = ST_DATA;
          else                                 state_nxt = ST_CHECK;
        end
      end
      ST_INSTR: begin
        if (section_last) state_nxt = (hdr_q.dcount != 16'd0) ? ST_DATA : ST_CHECK;
      end
      ST_DATA: begin
        if (section_last) state_nxt = ST_CHECK;
      end
      ST_CHECK: begin
        if (byte_acc) state_nxt = (in_byte == csum) ? ST_RUN : ST_ERROR;
      end
      ST_RUN: begin
        if (end_signal) state_nxt = ST_DONE;
      end
      default: state_nxt = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hdr_cnt    <= '0;
      hdr_shift  <= '0;
      hdr_q      <= '0;
      word_cnt   <= '0;
      csum       <= '0;
      add_into_q <= 1'b0;
    end else begin
      if (byte_acc && (state == ST_HDR)) begin
        hdr_cnt   <= hdr_cnt + 2'd1;
        hdr_shift <= {in_byte, hdr_shift[23:8]};
        csum      <= csum ^ in_byte;
        if (hdr_last) hdr_q <= hdr_full;
      end
      if (pk_vld) begin
        csum <= csum ^ in_byte;
        if (word_last) word_cnt <= section_last ? 16'd0 : word_cnt + 16'd1;
      end
      // Flips together with the first data word's strobe, so the last instr load still sees 0.
      if ((state == ST_DATA) && word_last) add_into_q <= 1'b1;
    end
  end

  assign add_into     = add_into_q;
  assign start_signal = (state == ST_RUN) || (state == ST_DONE);
  assign done         = (state == ST_DONE);
  assign error        = (state == ST_ERROR);

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: frames built from word lists, expected loads queued up front
// and popped by an independent monitor whenever load_valid is seen.
module tb_program_loader;

  localparam int MAX_INSTR = 1024;
  localparam int MAX_DATA  = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] new_instruction;
  logic        load_valid;
  logic        add_into;
  logic        start_signal;
  logic        end_signal;
  logic        done;
  logic        error;

  always #5 clk = ~clk;

  program_loader dut (
    .clk             (clk),
    .reset           (reset),
    .in_byte         (in_byte),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .new_instruction (new_instruction),
    .load_valid      (load_valid),
    .add_into        (add_into),
    .start_signal    (start_signal),
    .end_signal      (end_signal),
    .done            (done),
    .error           (error)
  );

  typedef struct packed {
    logic [31:0] w;
    logic        a;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] iw[$];
  logic [31:0] dw[$];
  logic [7:0]  garb[3] = '{8'h00, 8'hFF, 8'h12};
  int          checks = 0;
  int          errors = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (!reset && load_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_load: got %h add_into=%b, no load expected", new_instruction, add_into);
      end else begin
        mon_e = sb.pop_front();
        chk("load_word", new_instruction, mon_e.w);
        chk("load_add_into", 32'(add_into), 32'(mon_e.a));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b);
    int waited;
    @(negedge clk);
    repeat ($urandom_range(0, 2)) begin
      in_byte = 8'($urandom);
      @(negedge clk);
    end
    waited = 0;
    while (!in_ready && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: in_ready=%b required 1", in_ready);
    end else begin
      in_byte  = b;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_byte  = 8'($urandom);
    end
  endtask

  task automatic send_words(input logic [31:0] w, inout logic [7:0] cs);
    for (int k = 0; k < 4; k++) begin
      end_signal = 1'($urandom);
      send_byte(w[8*k +: 8]);
      cs = cs ^ w[8*k +: 8];
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset      = 1'b1;
    in_valid   = 1'b0;
    end_signal = 1'b0;
    repeat (2) @(negedge clk);
    sb.delete();
    reset = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_load_valid", 32'(load_valid), 32'd0);
    chk("rst_new_instruction", new_instruction, 32'd0);
    chk("rst_add_into", 32'(add_into), 32'd0);
    chk("rst_start", 32'(start_signal), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    end_signal = 1'b1;
    repeat (2) @(negedge clk);
    end_signal = 1'b0;
    chk("end_ignored_idle_done", 32'(done), 32'd0);
    chk("end_ignored_idle_start", 32'(start_signal), 32'd0);
  endtask

  // Builds and sends a whole frame from iw/dw, checking the outcome the frame rules predict.
  task automatic run_frame(input int icnt, input int dcnt, input logic [7:0] flip, input int garbage);
    logic [7:0]  cs;
    logic [15:0] ic;
    logic [15:0] dc;
    logic [7:0]  hb[4];
    bit          hdr_ok;
    bit          good;
    ic     = 16'(icnt);
    dc     = 16'(dcnt);
    hdr_ok = (icnt <= MAX_INSTR) && (dcnt <= MAX_DATA);
    good   = hdr_ok && (flip == 8'h00);
    for (int g = 0; g < garbage; g++) send_byte(garb[g % 3]);
    send_byte(8'hB5);
    cs = 8'h00;
    hb = '{ic[7:0], ic[15:8], dc[7:0], dc[15:8]};
    for (int h = 0; h < 4; h++) begin
      send_byte(hb[h]);
      cs = cs ^ hb[h];
    end
    if (!hdr_ok) begin
      @(negedge clk);
      chk("hdr_limit_error", 32'(error), 32'd1);
      chk("hdr_limit_in_ready", 32'(in_ready), 32'd0);
      chk("hdr_limit_start", 32'(start_signal), 32'd0);
      repeat (3) @(negedge clk);
      chk("hdr_limit_error_sticky", 32'(error), 32'd1);
      return;
    end
    foreach (iw[i]) sb.push_back({iw[i], 1'b0});
    foreach (dw[i]) sb.push_back({dw[i], 1'b1});
    foreach (iw[i]) send_words(iw[i], cs);
    foreach (dw[i]) send_words(dw[i], cs);
    end_signal = 1'b0;
    send_byte(cs ^ flip);
    @(negedge clk);
    chk("start_after_csum", 32'(start_signal), 32'(good));
    chk("error_after_csum", 32'(error), 32'(!good));
    chk("in_ready_after_csum", 32'(in_ready), 32'd0);
    chk("all_words_loaded", 32'(sb.size()), 32'd0);
    chk("add_into_final", 32'(add_into), 32'(dcnt > 0));
    if (good) begin
      chk("done_before_end", 32'(done), 32'd0);
      end_signal = 1'b1;
      @(negedge clk);
      end_signal = 1'b0;
      chk("done_after_end", 32'(done), 32'd1);
      chk("start_held_in_done", 32'(start_signal), 32'd1);
    end else begin
      end_signal = 1'b1;
      repeat (2) @(negedge clk);
      end_signal = 1'b0;
      chk("bad_csum_error_sticky", 32'(error), 32'd1);
      chk("bad_csum_start_low", 32'(start_signal), 32'd0);
      chk("bad_csum_no_done", 32'(done), 32'd0);
    end
  endtask

  task automatic load_example();
    iw = '{32'h0000_0013, 32'h0010_0093};
    dw = '{32'hDEAD_BEEF};
  endtask

  initial begin
    logic [7:0] partial[11];
    int ic, dc, gb;
    logic [7:0] fl;
    reset      = 1'b1;
    in_byte    = 8'h00;
    in_valid   = 1'b0;
    end_signal = 1'b0;

    do_reset();
    load_example();
    run_frame(2, 1, 8'h00, 0);

    do_reset();
    run_frame(2, 1, 8'h01, 0);

    do_reset();
    run_frame(2, 1, 8'h00, 3);

    do_reset();
    iw.delete();
    dw.delete();
    run_frame(0, 0, 8'h00, 0);

    do_reset();
    run_frame(MAX_INSTR + 1, 0, 8'h00, 0);

    // Reset lands inside the second instruction word.
    do_reset();
    sb.push_back({32'h0000_0013, 1'b0});
    partial = '{8'hB5, 8'h02, 8'h00, 8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00};
    for (int i = 0; i < 11; i++) send_byte(partial[i]);
    repeat (2) @(negedge clk);
    chk("midreset_first_word", 32'(sb.size()), 32'd0);
    do_reset();
    load_example();
    run_frame(2, 1, 8'h00, 0);

    for (int r = 0; r < 8; r++) begin
      do_reset();
      ic = $urandom_range(0, 5);
      dc = $urandom_range(0, 5);
      gb = $urandom_range(0, 3);
      fl = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      iw.delete();
      dw.delete();
      for (int i = 0; i < ic; i++) iw.push_back($urandom);
      for (int i = 0; i < dc; i++) dw.push_back($urandom);
      run_frame(ic, dc, fl, gb);
    end

    do_reset();
    iw.delete();
    dw.delete();
    run_frame(0, MAX_DATA + $urandom_range(1, 50), 8'h00, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
